// File: rtl/minterm_sweep_ctrl_if.sv
// Bus bundle between the minterm sweep controller and the block that drives it.
// The master side launches and aborts sweeps and returns f2/f3 from the logic
// under test. The slave side (the controller) drives the stimulus and reports results.
interface minterm_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       f2;
  logic       f3;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [7:0] tt_f2;
  logic [7:0] tt_f3;
  logic [3:0] err_cnt;
  logic       pass;

  modport master (
    output start, abort, f2, f3,
    input  a, b, c, busy, done, tt_f2, tt_f3, err_cnt, pass
  );

  modport slave (
    input  start, abort, f2, f3,
    output a, b, c, busy, done, tt_f2, tt_f3, err_cnt, pass
  );
endinterface

// File: rtl/minterm_sweep_ctrl.sv
// Minterm sweep controller: walks a/b/c through all eight minterms of the
// 3-input f2/f3 logic, captures both truth tables, and counts minterms that
// disagree with the expected tables. A start/done handshake frames each sweep.
module minterm_sweep_ctrl #(
  parameter int         SETTLE = 1,
  parameter logic [7:0] EXP_F2 = 8'h28,
  parameter logic [7:0] EXP_F3 = 8'hC0
) (
  input logic                clk,
  input logic                rst,
  minterm_sweep_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tt_f2_q, tt_f2_d;
  logic [7:0]    tt_f3_q, tt_f3_d;
  logic [3:0]    err_q, err_d;
  logic          pass_q, pass_d;
  logic          mismatch;

  // Sweep sequencing: launch, per-minterm settle/sample, abort and completion.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tt_f2_d  = tt_f2_q;
    tt_f3_d  = tt_f3_q;
    err_d    = err_q;
    pass_d   = pass_q;
    mismatch = 1'b0;
    unique case (state_q)
      IDLE: begin
        // start beats abort here; abort alone means nothing in IDLE
        if (bus.start) begin
          state_d = DRIVE;
          idx_d   = 3'd0;
          cnt_d   = CNT_ONE;
          tt_f2_d = 8'h00;
          tt_f3_d = 8'h00;
          err_d   = 4'd0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          // partial tables and count are kept; a/b/c hold the last minterm
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q == SETTLE_C) begin
          tt_f2_d[idx_q] = bus.f2;
          tt_f3_d[idx_q] = bus.f3;
          mismatch = ({bus.f3, bus.f2} != {EXP_F3[idx_q], EXP_F2[idx_q]});
          if (mismatch && (err_q != 4'd8)) begin
            err_d = err_q + 4'd1;
          end
          if (idx_q == 3'd7) begin
            // pass reflects the count including this last compare
            state_d = DONE;
            pass_d  = (err_d == 4'd0);
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset clears everything mid-sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      tt_f2_q <= 8'h00;
      tt_f3_q <= 8'h00;
      err_q   <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_f2_q <= tt_f2_d;
      tt_f3_q <= tt_f3_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.a       = idx_q[0];
  assign bus.b       = idx_q[1];
  assign bus.c       = idx_q[2];
  assign bus.busy    = (state_q == DRIVE);
  assign bus.done    = (state_q == DONE);
  assign bus.tt_f2   = tt_f2_q;
  assign bus.tt_f3   = tt_f3_q;
  assign bus.err_cnt = err_q;
  assign bus.pass    = pass_q;

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Bench for minterm_sweep_ctrl: a behavioural f2/f3 logic model feeds two
// controllers (SETTLE=1 and SETTLE=3); expected sweep results are queued at
// launch and checked by monitors when done pulses.
module tb_minterm_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  minterm_sweep_ctrl_if if1 ();
  minterm_sweep_ctrl_if if3 ();

  minterm_sweep_ctrl #(.SETTLE(1), .EXP_F2(8'h28), .EXP_F3(8'hC0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  minterm_sweep_ctrl #(.SETTLE(3), .EXP_F2(8'h28), .EXP_F3(8'hC0)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  // Reference truth tables for the logic under test
  logic [7:0] f2_tab = 8'h28;
  logic [7:0] f3_tab = 8'hC0;
  logic       f3_kill = 1'b0;
  logic       f_inv   = 1'b0;

  assign if1.f2 = f2_tab[{if1.c, if1.b, if1.a}] ^ f_inv;
  assign if1.f3 = f_inv ? ~f3_tab[{if1.c, if1.b, if1.a}]
                        : (f3_kill ? 1'b0 : f3_tab[{if1.c, if1.b, if1.a}]);
  assign if3.f2 = f2_tab[{if3.c, if3.b, if3.a}];
  assign if3.f3 = f3_tab[{if3.c, if3.b, if3.a}];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         start_cyc;
    int         lat;
    logic [7:0] f2;
    logic [7:0] f3;
    logic [3:0] err;
    logic       pass;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t m1;
  exp_t m3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor for the SETTLE=1 controller
  always @(negedge clk) begin
    if (if1.done === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected done", 32'd1, 32'd0);
      end else begin
        m1 = q1.pop_front();
        chk("dut1 done latency", cyc - m1.start_cyc, m1.lat);
        chk("dut1 tt_f2", if1.tt_f2, m1.f2);
        chk("dut1 tt_f3", if1.tt_f3, m1.f3);
        chk("dut1 err_cnt", if1.err_cnt, m1.err);
        chk("dut1 pass", if1.pass, m1.pass);
        chk("dut1 busy at done", if1.busy, 32'd0);
      end
    end
  end

  // Scoreboard monitor for the SETTLE=3 controller
  always @(negedge clk) begin
    if (if3.done === 1'b1) begin
      if (q3.size() == 0) begin
        chk("dut3 unexpected done", 32'd1, 32'd0);
      end else begin
        m3 = q3.pop_front();
        chk("dut3 done latency", cyc - m3.start_cyc, m3.lat);
        chk("dut3 tt_f2", if3.tt_f2, m3.f2);
        chk("dut3 tt_f3", if3.tt_f3, m3.f3);
        chk("dut3 err_cnt", if3.err_cnt, m3.err);
        chk("dut3 pass", if3.pass, m3.pass);
      end
    end
  end

  // Launch a sweep on dut1; returns at the negedge of cycle 1
  task automatic launch1(input bit push, input logic [7:0] ef2, input logic [7:0] ef3,
                         input logic [3:0] ee, input logic ep, input logic abt);
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.start_cyc = cyc;
      e.lat       = 9;
      e.f2        = ef2;
      e.f3        = ef3;
      e.err       = ee;
      e.pass      = ep;
      q1.push_back(e);
    end
    if1.start = 1'b1;
    if1.abort = abt;
    @(negedge clk);
    if1.start = 1'b0;
    if1.abort = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    if1.start = 1'b0; if1.abort = 1'b0;
    if3.start = 1'b0; if3.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset abc", {if1.c, if1.b, if1.a}, 32'd0);
    chk("reset busy/done/pass", {if1.busy, if1.done, if1.pass}, 32'd0);
    chk("reset tables", {if1.tt_f3, if1.tt_f2}, 32'd0);
    chk("reset err_cnt", if1.err_cnt, 32'd0);
    rst = 1'b0;

    // T1: correct logic, SETTLE=1
    launch1(1'b1, 8'h28, 8'hC0, 4'd0, 1'b1, 1'b0);
    chk("t1 abc cycle 1", {if1.c, if1.b, if1.a}, 32'd0);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      chk("t1 abc", {if1.c, if1.b, if1.a}, i - 1);
      chk("t1 busy", if1.busy, 32'd1);
    end
    repeat (2) @(negedge clk);
    chk("t1 done one cycle", if1.done, 32'd0);
    chk("t1 pass held", if1.pass, 32'd1);
    chk("t1 abc after done", {if1.c, if1.b, if1.a}, 32'd7);

    // T3: f3 stuck at 0
    f3_kill = 1'b1;
    launch1(1'b1, 8'h28, 8'h00, 4'd2, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    f3_kill = 1'b0;

    // T4: abort while idx=4
    launch1(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4 abc before abort", {if1.c, if1.b, if1.a}, 32'd4);
    if1.abort = 1'b1;
    @(negedge clk);
    if1.abort = 1'b0;
    chk("t4 busy after abort", if1.busy, 32'd0);
    chk("t4 tt_f2 partial", if1.tt_f2, 32'h08);
    chk("t4 tt_f3 partial", if1.tt_f3, 32'h00);
    chk("t4 pass", if1.pass, 32'd0);
    chk("t4 abc held", {if1.c, if1.b, if1.a}, 32'd4);
    if1.abort = 1'b1;
    repeat (2) @(negedge clk);
    if1.abort = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4 still idle", if1.busy, 32'd0);

    // T5: second start mid-sweep is ignored
    launch1(1'b1, 8'h28, 8'hC0, 4'd0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5 abc at restart", {if1.c, if1.b, if1.a}, 32'd2);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    chk("t5 abc continues", {if1.c, if1.b, if1.a}, 32'd3);
    repeat (6) @(negedge clk);

    // T7: every minterm wrong, start+abort together in IDLE
    f_inv = 1'b1;
    launch1(1'b1, 8'hD7, 8'h3F, 4'd8, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    f_inv = 1'b0;

    // T6: asynchronous reset while idx=5, then a clean sweep
    launch1(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("t6 abc before reset", {if1.c, if1.b, if1.a}, 32'd5);
    rst = 1'b1;
    #1;
    chk("t6 abc reset", {if1.c, if1.b, if1.a}, 32'd0);
    chk("t6 busy/done/pass reset", {if1.busy, if1.done, if1.pass}, 32'd0);
    chk("t6 tables reset", {if1.tt_f3, if1.tt_f2}, 32'd0);
    chk("t6 err_cnt reset", if1.err_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    launch1(1'b1, 8'h28, 8'hC0, 4'd0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    // T2: SETTLE=3 on the second controller
    @(negedge clk);
    e.start_cyc = cyc;
    e.lat       = 25;
    e.f2        = 8'h28;
    e.f3        = 8'hC0;
    e.err       = 4'd0;
    e.pass      = 1'b1;
    q3.push_back(e);
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) @(negedge clk);
      chk("t2 abc", {if3.c, if3.b, if3.a}, (k - 1) / 3);
    end
    repeat (3) @(negedge clk);

    chk("dut1 sweeps completed", q1.size(), 32'd0);
    chk("dut3 sweeps completed", q3.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
